pwm_preconditioner: RTL
=======================

Name: pwm_preconditioner

Overview:
- Consumer end of the silencer output interface.
- On each silencer completion pulse, converts the per-transducer smoothed duty/phase into PWM rise/fall edge times, one transducer per clock.
- Publishes all edges atomically to the PWM generator, with a one-cycle completion pulse.
- Sits between the silencer and the per-transducer PWM counters/comparators.

Parameters:
- WIDTH, 13, bit width of cycle/duty/phase/edge values.
- DEPTH, 249, number of transducers.

Ports:
- CLK  input  1  system clock.
- RST  input  1  reset; asynchronous, active-high.
- START  input  1  one-cycle pulse from the silencer (its completion output); begins a conversion pass.
- CYCLE  input  WIDTH x DEPTH  PWM period per transducer, valid range 2..2^WIDTH-1.
- DUTY  input  WIDTH x DEPTH  smoothed duty (silencer output).
- PHASE  input  WIDTH x DEPTH  smoothed phase (silencer output).
- RISE  output  WIDTH x DEPTH  rising-edge time in [0, CYCLE-1].
- FALL  output  WIDTH x DEPTH  falling-edge time in [0, CYCLE].
- BUSY  output  1  high while a pass is in progress.
- DONE  output  1  one-cycle pulse when RISE/FALL are updated.
- OVERRUN  output  1  sticky flag: START arrived while BUSY.

Behaviour:
- Reset (asynchronous, any time):
  - All RISE/FALL clear to 0; BUSY, DONE and OVERRUN clear to 0.
  - The FSM goes to IDLE and the index counter goes to 0.
  - Reset mid-pass abandons the pass: no DONE, outputs remain 0.
- FSM states:
  - IDLE: START=1 -> RUN, idx=0, BUSY=1.
  - RUN: idx increments each cycle. After idx=DEPTH-1 is issued -> DRAIN.
  - DRAIN: waits for the pipeline to empty -> LOAD.
  - LOAD: copies all shadow registers to RISE/FALL in one cycle, DONE=1, BUSY=0 -> IDLE.
- Pipeline:
  - Two stages. Stage 1 reads CYCLE/DUTY/PHASE[idx] live and computes the half-widths.
  - Stage 2 applies wrap correction and writes shadow[idx].
  - Inputs must stay stable during a pass; the silencer holds them between its pulses.
- Latency: DONE is high on exactly the DEPTH+3rd rising edge after the edge that sampled START. DONE is never longer than one cycle.
- Arithmetic, with internal width WIDTH+1 and signed intermediates:
  - ph = PHASE. If PHASE >= CYCLE, ph = PHASE - CYCLE (single correction).
  - lo = DUTY>>1 (floor); hi = (DUTY+1)>>1 (ceil), so lo+hi = DUTY.
  - r = ph - lo. If r < 0, r += CYCLE.
  - f = ph + hi. If f >= CYCLE, f -= CYCLE.
  - DUTY = 0 gives r = f = ph (zero width; the generator treats this as off).
- Output update: RISE/FALL change only in LOAD. The generator never sees a partially updated array.
- START handling:
  - START while BUSY (RUN/DRAIN/LOAD) is ignored and sets OVERRUN=1. Only reset clears OVERRUN.
  - START in the same cycle as LOAD is also ignored and sets OVERRUN.
  - A START arriving in IDLE one cycle after LOAD is accepted normally.

Optional Feature:
- Macro: PWM_PRECONDITIONER_DUTY_CLAMP_EN.
- Defined: DUTY >= CYCLE forces RISE=0, FALL=CYCLE (full-on) for that element. This takes priority over the wrap arithmetic.
- Not defined:
  - No comparison logic is built; DUTY is used raw through the same wrap arithmetic.
  - Results for DUTY >= CYCLE are outside the contract; verification does not check them.
  - Timing is identical either way.

Decomposition:
- Package pwm_pkg holds:
  - the FSM state enum (IDLE, RUN, DRAIN, LOAD);
  - default WIDTH/DEPTH localparams;
  - the pipeline latency constant (3) used by RTL and bench.
- One sub-module, pwm_edge_calc: the registered two-stage per-element rise/fall computation, including the clamp under the macro.
- The top level holds the FSM, index counter, shadow array and output array.

Test Plan:
- CYCLE=4096, DUTY=2048, PHASE=1024 on all elements, pulse START -> after DEPTH+3 edges DONE=1 for one cycle; RISE=0, FALL=2048 everywhere.
- Wrap low, CYCLE=4096, PHASE=0, DUTY=100 -> RISE=4046, FALL=50.
- Wrap high, PHASE=4095, DUTY=3 -> RISE=4094, FALL=1.
- DUTY=0, PHASE=7 -> RISE=7, FALL=7.
- Clamp, with macro: DUTY=5000, CYCLE=4096 -> RISE=0, FALL=4096.
- Second START 10 cycles into a pass -> OVERRUN=1 and stays 1. Only one DONE is produced, at DEPTH+3, and the second START does not start a pass.
- Assert RST at idx=100 -> all outputs 0 immediately, no DONE. A fresh START after reset produces a correct pass.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM preconditioner: default sizes, the pass
// FSM state encoding and the edge-calculation pipeline latency.
package pwm_pkg;

  localparam int DEF_WIDTH = 13;
  localparam int DEF_DEPTH = 249;

  // Edges from issuing an element to its result landing in the shadow array:
  // stage 1 register, stage 2 register, shadow write.
  localparam int PIPE_LAT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    LOAD  = 2'd3
  } pwm_state_t;

endpackage

// File: rtl/pwm_edge_calc.sv
// Two-stage registered rise/fall edge calculation for one transducer per
// clock. Stage 1 folds the phase into [0, cycle) and splits the duty into
// floor/ceil halves; stage 2 wraps the edges back into the period.
// Build option: PWM_PRECONDITIONER_DUTY_CLAMP_EN forces full-on output
// (rise = 0, fall = cycle) when duty >= cycle.
module pwm_edge_calc
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] cycle,
  input  logic [WIDTH-1:0] duty,
  input  logic [WIDTH-1:0] phase,
  output logic             result_valid,
  output logic [IDX_W-1:0] result_idx,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Stage 1 combinational terms
  logic [WIDTH-1:0] ph_calc;
  logic [WIDTH-1:0] lo_calc;
  logic [WIDTH-1:0] hi_calc;

  // Stage 1 registers
  logic             s1_valid_reg;
  logic [IDX_W-1:0] s1_idx_reg;
  logic [WIDTH-1:0] s1_cycle_reg;
  logic [WIDTH-1:0] s1_ph_reg;
  logic [WIDTH-1:0] s1_lo_reg;
  logic [WIDTH-1:0] s1_hi_reg;
`ifdef PWM_PRECONDITIONER_DUTY_CLAMP_EN
  logic             s1_clamp_reg;
`endif

  // Stage 2 combinational terms. r_raw is two's complement with bit WIDTH
  // as the sign; |ph - lo| < 2^WIDTH so one extra bit is enough. f_raw is
  // unsigned and needs the extra bit because ph + hi can reach ~1.5 periods.
  logic [WIDTH:0]   r_raw;
  logic [WIDTH:0]   f_raw;
  logic [WIDTH-1:0] rise_calc;
  logic [WIDTH-1:0] fall_calc;

  // Phase fold (single correction) and duty half-widths; lo + hi == duty.
  always_comb begin
    ph_calc = (phase >= cycle) ? (phase - cycle) : phase;
    lo_calc = duty >> 1;
    hi_calc = lo_calc + {{(WIDTH-1){1'b0}}, duty[0]};
  end

  // Stage 1 register: capture folded phase, half-widths and the period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_idx_reg   <= '0;
      s1_cycle_reg <= '0;
      s1_ph_reg    <= '0;
      s1_lo_reg    <= '0;
      s1_hi_reg    <= '0;
`ifdef PWM_PRECONDITIONER_DUTY_CLAMP_EN
      s1_clamp_reg <= 1'b0;
`endif
    end else begin
      s1_valid_reg <= valid;
      s1_idx_reg   <= idx;
      s1_cycle_reg <= cycle;
      s1_ph_reg    <= ph_calc;
      s1_lo_reg    <= lo_calc;
      s1_hi_reg    <= hi_calc;
`ifdef PWM_PRECONDITIONER_DUTY_CLAMP_EN
      s1_clamp_reg <= (duty >= cycle);
`endif
    end
  end

  // Wrap correction. The corrected values always lie inside [0, cycle), so
  // the add/subtract of the period can be done modulo 2^WIDTH.
  always_comb begin
    r_raw     = {1'b0, s1_ph_reg} - {1'b0, s1_lo_reg};
    f_raw     = {1'b0, s1_ph_reg} + {1'b0, s1_hi_reg};
    rise_calc = r_raw[WIDTH] ? (r_raw[WIDTH-1:0] + s1_cycle_reg) : r_raw[WIDTH-1:0];
    fall_calc = (f_raw >= {1'b0, s1_cycle_reg}) ? (f_raw[WIDTH-1:0] - s1_cycle_reg)
                                                : f_raw[WIDTH-1:0];
`ifdef PWM_PRECONDITIONER_DUTY_CLAMP_EN
    if (s1_clamp_reg) begin
      rise_calc = '0;
      fall_calc = s1_cycle_reg;
    end
`endif
  end

  // Stage 2 register: final edges plus the element index they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_valid <= 1'b0;
      result_idx   <= '0;
      rise         <= '0;
      fall         <= '0;
    end else begin
      result_valid <= s1_valid_reg;
      result_idx   <= s1_idx_reg;
      rise         <= rise_calc;
      fall         <= fall_calc;
    end
  end

endmodule

// File: rtl/pwm_preconditioner.sv
// PWM preconditioner top: on each START pulse walks all transducers through
// the edge calculator one per clock, collects results in a shadow array and
// then publishes every RISE/FALL in a single LOAD cycle with a DONE pulse.
// Build option: PWM_PRECONDITIONER_DUTY_CLAMP_EN (handled in pwm_edge_calc).
module pwm_preconditioner
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic [WIDTH*DEPTH-1:0] CYCLE,
  input  logic [WIDTH*DEPTH-1:0] DUTY,
  input  logic [WIDTH*DEPTH-1:0] PHASE,
  output logic [WIDTH*DEPTH-1:0] RISE,
  output logic [WIDTH*DEPTH-1:0] FALL,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   OVERRUN
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
  // DRAIN lasts PIPE_LAT-1 cycles so the last shadow write precedes LOAD.
  localparam logic [1:0] DRAIN_LAST = 2'(PIPE_LAT - 2);

  pwm_state_t       state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [1:0]       drain_cnt_reg, drain_cnt_next;
  logic             done_reg;
  logic             overrun_reg;

  logic             issue_valid;
  logic [WIDTH-1:0] cycle_sel;
  logic [WIDTH-1:0] duty_sel;
  logic [WIDTH-1:0] phase_sel;

  logic             result_valid;
  logic [IDX_W-1:0] result_idx;
  logic [WIDTH-1:0] rise_res;
  logic [WIDTH-1:0] fall_res;

  logic [WIDTH-1:0] shadow_rise [DEPTH];
  logic [WIDTH-1:0] shadow_fall [DEPTH];

  // Live element selection; inputs are held stable by the silencer for a pass.
  assign issue_valid = (state_reg == RUN);
  assign cycle_sel   = CYCLE[idx_reg*WIDTH +: WIDTH];
  assign duty_sel    = DUTY[idx_reg*WIDTH +: WIDTH];
  assign phase_sel   = PHASE[idx_reg*WIDTH +: WIDTH];

  assign BUSY    = (state_reg != IDLE);
  assign DONE    = done_reg;
  assign OVERRUN = overrun_reg;

  pwm_edge_calc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_edge_calc (
    .clk          (CLK),
    .rst          (RST),
    .valid        (issue_valid),
    .idx          (idx_reg),
    .cycle        (cycle_sel),
    .duty         (duty_sel),
    .phase        (phase_sel),
    .result_valid (result_valid),
    .result_idx   (result_idx),
    .rise         (rise_res),
    .fall         (fall_res)
  );

  // Pass sequencing: IDLE -> RUN (issue DEPTH elements) -> DRAIN -> LOAD.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    drain_cnt_next = drain_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (START) begin
          state_next = RUN;
          idx_next   = '0;
        end
      end
      RUN: begin
        if (idx_reg == IDX_LAST) begin
          state_next     = DRAIN;
          idx_next       = '0;
          drain_cnt_next = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt_reg == DRAIN_LAST) begin
          state_next = LOAD;
        end else begin
          drain_cnt_next = drain_cnt_reg + 1'b1;
        end
      end
      LOAD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control registers; START outside IDLE (including LOAD) is dropped and latched as overrun.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      drain_cnt_reg <= '0;
      done_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      drain_cnt_reg <= drain_cnt_next;
      done_reg      <= (state_reg == LOAD);
      overrun_reg   <= overrun_reg | (START & (state_reg != IDLE));
    end
  end

  // Shadow array collects results; it is fully rewritten on every pass, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (result_valid) begin
      shadow_rise[result_idx] <= rise_res;
      shadow_fall[result_idx] <= fall_res;
    end
  end

  // Published edges: every element copies its shadow entry in the same LOAD cycle.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_out
      logic [WIDTH-1:0] rise_reg;
      logic [WIDTH-1:0] fall_reg;

      // Atomic publish of one element's edges.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          rise_reg <= '0;
          fall_reg <= '0;
        end else if (state_reg == LOAD) begin
          rise_reg <= shadow_rise[gi];
          fall_reg <= shadow_fall[gi];
        end
      end

      assign RISE[gi*WIDTH +: WIDTH] = rise_reg;
      assign FALL[gi*WIDTH +: WIDTH] = fall_reg;
    end
  endgenerate

endmodule
